// File: rtl/lector_memoria_pkg.sv
// Shared definitions for the register-file burst reader: FSM encoding and default width.
package lector_memoria_pkg;
  localparam int N_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } estado_t;
endpackage

// File: rtl/lector_memoria_mux.sv
// mux_registro: combinational 16-to-1 N-bit word selector over the packed register file.
module mux_registro #(
  parameter int N = 16
) (
  input  logic [15:0][N-1:0] regs,
  input  logic [3:0]         sel,
  output logic [N-1:0]       palabra
);
  assign palabra = regs[sel];
endmodule

// File: rtl/lector_memoria.sv
// Burst reader: streams len+1 words from r1..r16 starting at addr, with valid/ready handshake.
// Optional LECTOR_CHECKSUM_EN adds a modulo-2^N sum of the transferred words.
module lector_memoria
  import lector_memoria_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   addr,
  input  logic [3:0]   len,
  input  logic         ready,
  input  logic [N-1:0] r1,
  input  logic [N-1:0] r2,
  input  logic [N-1:0] r3,
  input  logic [N-1:0] r4,
  input  logic [N-1:0] r5,
  input  logic [N-1:0] r6,
  input  logic [N-1:0] r7,
  input  logic [N-1:0] r8,
  input  logic [N-1:0] r9,
  input  logic [N-1:0] r10,
  input  logic [N-1:0] r11,
  input  logic [N-1:0] r12,
  input  logic [N-1:0] r13,
  input  logic [N-1:0] r14,
  input  logic [N-1:0] r15,
  input  logic [N-1:0] r16,
  output logic [N-1:0] dato,
  output logic         valid,
  output logic         busy,
  output logic         done
`ifdef LECTOR_CHECKSUM_EN
  ,
  output logic [N-1:0] checksum
`endif
);
  estado_t           state, state_nx;
  logic [3:0]        ptr, cnt, sel;
  logic              carga, xfer;
  logic [N-1:0]      palabra;
  logic [15:0][N-1:0] regs;

  assign regs = {r16, r15, r14, r13, r12, r11, r10, r9, r8, r7, r6, r5, r4, r3, r2, r1};

  mux_registro #(.N(N)) u_mux (
    .regs    (regs),
    .sel     (sel),
    .palabra (palabra)
  );

  assign xfer  = (state == READ) && ready;
  assign valid = (state == READ);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // In IDLE the mux looks at addr for the first word; in READ it prefetches ptr+1.
  always_comb begin
    state_nx = state;
    carga    = 1'b0;
    sel      = ptr + 4'd1;
    case (state)
      IDLE: begin
        sel = addr;
        if (start) begin
          carga    = 1'b1;
          state_nx = READ;
        end
      end
      READ:    if (ready && cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      cnt  <= '0;
      dato <= '0;
    end else if (carga) begin
      ptr  <= addr;
      cnt  <= len;
      dato <= palabra;
    end else if (xfer && cnt != 4'd0) begin
      ptr  <= ptr + 4'd1;
      cnt  <= cnt - 4'd1;
      dato <= palabra;
    end
  end

`ifdef LECTOR_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || carga) checksum <= '0;
    else if (xfer)    checksum <= checksum + dato;
  end
`endif
endmodule

// File: tb/tb_lector_memoria.sv
// Self-checking bench for lector_memoria: directed scenarios plus randomized traffic vs a queue-based model.
module tb_lector_memoria;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst, start, ready;
  logic [3:0]   addr, len;
  logic [N-1:0] regs [16];
  logic [N-1:0] dato;
  logic         valid, busy, done;
`ifdef LECTOR_CHECKSUM_EN
  logic [N-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lector_memoria #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len), .ready(ready),
    .r1(regs[0]),   .r2(regs[1]),   .r3(regs[2]),   .r4(regs[3]),
    .r5(regs[4]),   .r6(regs[5]),   .r7(regs[6]),   .r8(regs[7]),
    .r9(regs[8]),   .r10(regs[9]),  .r11(regs[10]), .r12(regs[11]),
    .r13(regs[12]), .r14(regs[13]), .r15(regs[14]), .r16(regs[15]),
    .dato(dato), .valid(valid), .busy(busy), .done(done)
`ifdef LECTOR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Reference model: a burst is a queue of register indices still to be presented.
  int           m_q[$];
  logic [N-1:0] m_dato;
  logic [N-1:0] m_sum;
  logic         m_valid, m_done, m_rst;

  always @(posedge clk) begin
    m_rst = rst;
    if (rst) begin
      m_q.delete();
      m_dato = '0; m_sum = '0; m_valid = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_valid) begin
      if (ready) begin
        m_sum = m_sum + m_dato;
        if (m_q.size() > 0) m_dato = regs[m_q.pop_front()];
        else begin m_valid = 0; m_done = 1; end
      end
    end else if (start) begin
      m_q.delete();
      for (int k = 0; k <= int'(len); k++) m_q.push_back((int'(addr) + k) % 16);
      m_dato  = regs[m_q.pop_front()];
      m_valid = 1;
      m_sum   = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_checks();
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_valid | m_done));
    chk("done", 32'(done), 32'(m_done));
    if (m_valid || m_rst) chk("dato", 32'(dato), 32'(m_dato));
`ifdef LECTOR_CHECKSUM_EN
    if (m_done || m_rst) chk("checksum", 32'(checksum), 32'(m_sum));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_checks();
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 16; i++) regs[i] = '0;
  endtask

  task automatic load_wrap();
    clear_regs();
    regs[13] = 16'h8004; regs[14] = 16'hA204; regs[15] = 16'h8004; regs[0] = 16'h0003;
  endtask

  logic [N-1:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 16'h8004; wrap_seq[1] = 16'hA204; wrap_seq[2] = 16'h8004; wrap_seq[3] = 16'h0003;
    clear_regs();
    rst = 1; start = 0; ready = 1; addr = 0; len = 0;
    @(negedge clk);
    tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dato", 32'(dato), 32'd0);
    rst = 0;
    tick();

    // Single read
    regs[6] = 16'h0025; addr = 6; len = 0; start = 1;
    tick();
    start = 0;
    chk("single_dato", 32'(dato), 32'h0025);
    chk("single_valid", 32'(valid), 32'd1);
    tick();
    chk("single_done", 32'(done), 32'd1);
    chk("single_novalid", 32'(valid), 32'd0);
    tick();
    chk("single_idle", 32'(busy), 32'd0);

    // Wrap burst
    load_wrap(); addr = 13; len = 3; start = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 0;
      chk("wrap_dato", 32'(dato), 32'(wrap_seq[i]));
    end
    tick();
    chk("wrap_done", 32'(done), 32'd1);
    tick();

    // Backpressure at the second word
    addr = 13; len = 3; start = 1;
    tick();
    start = 0;
    tick();
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_dato", 32'(dato), 32'hA204);
      chk("bp_valid", 32'(valid), 32'd1);
    end
    ready = 1;
    tick();
    chk("bp_resume", 32'(dato), 32'h8004);
    tick();
    chk("bp_last", 32'(dato), 32'h0003);
    tick();
    chk("bp_done", 32'(done), 32'd1);
    tick();

    // Start while busy is ignored
    addr = 13; len = 3; start = 1;
    tick();
    addr = 0; len = 0;
    tick();
    chk("sb_dato", 32'(dato), 32'hA204);
    start = 0;
    tick();
    chk("sb_dato2", 32'(dato), 32'h8004);
    tick();
    chk("sb_dato3", 32'(dato), 32'h0003);
    tick();
    chk("sb_done", 32'(done), 32'd1);
    tick();

    // Reset mid-burst: no done pulse
    addr = 13; len = 3; start = 1;
    tick();
    start = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rb_valid", 32'(valid), 32'd0);
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_dato", 32'(dato), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rb_nodone", 32'(done), 32'd0);
    end

    // Checksum burst
    clear_regs();
    regs[0] = 3; regs[1] = 2; regs[2] = 1; regs[3] = 1;
    addr = 0; len = 3; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("cs_done", 32'(done), 32'd1);
`ifdef LECTOR_CHECKSUM_EN
    chk("cs_sum", 32'(checksum), 32'h0007);
`endif
    tick();

    // Randomized traffic; registers change every cycle to exercise load-edge sampling
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 16; i++) regs[i] = N'($urandom);
      start = ($urandom_range(0, 3) == 0);
      addr  = 4'($urandom);
      len   = 4'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
